// File: rtl/prime_seq_ctrl.sv
// prime_seq_ctrl: sequential trial-division prime tester.
//
// One candidate divisor is evaluated per clock so that wide operands never
// need an unrolled modulo chain. A start/busy/done handshake connects it to
// the surrounding maths datapath; the verdict and the smallest nontrivial
// factor stay on the outputs until a later test completes.
//
// Build option:
//   PRIME_SQRT_BOUND_EN - when defined, the search stops once i*i > a_q
//                         (2N-bit product) instead of i >= a_q. Results are
//                         unchanged; only the latency for primes shrinks.
module prime_seq_ctrl #(
    parameter int N = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    output logic         busy,
    output logic         done,
    output logic         is_prime,
    output logic [N-1:0] factor
);

    localparam logic [N-1:0] ONE = N'(1);
    localparam logic [N-1:0] TWO = N'(2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;

    logic [N-1:0] r_a_q;
    logic [N-1:0] r_i;
    logic         r_is_prime;
    logic [N-1:0] r_factor;

    logic [N-1:0] w_a_q_nxt;
    logic [N-1:0] w_i_nxt;
    logic         w_is_prime_nxt;
    logic [N-1:0] w_factor_nxt;

    logic         w_lt2;
    logic         w_bound;
    logic         w_divides;
    logic [N-1:0] w_divisor;
    logic [N-1:0] w_rem;

    // Operands below 2 are neither prime nor composite; they exit on the
    // first CHECK cycle ahead of every other test.
    assign w_lt2 = (r_a_q < TWO);

    // r_i is only ever 0 while idle after reset; substituting 1 there keeps
    // the divider from seeing a zero divisor, and the quotient is unused then.
    assign w_divisor = (r_i == '0) ? ONE : r_i;
    assign w_rem     = r_a_q % w_divisor;
    assign w_divides = (w_rem == '0);

`ifdef PRIME_SQRT_BOUND_EN
    logic [2*N-1:0] w_sq;

    // Any composite has a factor no larger than its square root, so once
    // i*i exceeds a_q no divisor remains. The product is kept at 2N bits so
    // it can never wrap.
    assign w_sq    = {{N{1'b0}}, r_i} * {{N{1'b0}}, r_i};
    assign w_bound = (w_sq > {{N{1'b0}}, r_a_q});
`else
    // Linear bound: reaching i == a_q means no smaller divisor exists. Since
    // a_q <= 2^N-1, the counter stops before it could wrap.
    assign w_bound = (r_i >= r_a_q);
`endif

    // Next-state and next-register values; every target holds by default.
    always_comb begin
        w_state_nxt    = r_state;
        w_a_q_nxt      = r_a_q;
        w_i_nxt        = r_i;
        w_is_prime_nxt = r_is_prime;
        w_factor_nxt   = r_factor;

        case (r_state)
            S_IDLE: begin
                // Only here is start honoured; the operand is captured so
                // that a may change freely for the rest of the test.
                if (start) begin
                    w_a_q_nxt   = a;
                    w_i_nxt     = TWO;
                    w_state_nxt = S_CHECK;
                end
            end

            S_CHECK: begin
                // Strict priority: tiny operand, then bound, then divisor.
                if (w_lt2) begin
                    w_is_prime_nxt = 1'b0;
                    w_factor_nxt   = '0;
                    w_state_nxt    = S_DONE;
                end else if (w_bound) begin
                    w_is_prime_nxt = 1'b1;
                    w_factor_nxt   = '0;
                    w_state_nxt    = S_DONE;
                end else if (w_divides) begin
                    w_is_prime_nxt = 1'b0;
                    w_factor_nxt   = r_i;
                    w_state_nxt    = S_DONE;
                end else begin
                    w_i_nxt = r_i + ONE;
                end
            end

            S_DONE: begin
                // A start seen in this cycle is dropped, not queued.
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any test in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_a_q      <= '0;
            r_i        <= '0;
            r_is_prime <= 1'b0;
            r_factor   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_a_q      <= w_a_q_nxt;
            r_i        <= w_i_nxt;
            r_is_prime <= w_is_prime_nxt;
            r_factor   <= w_factor_nxt;
        end
    end

    // Handshake outputs decode straight from the state register, so done is
    // high for exactly the single DONE cycle and busy covers CHECK and DONE.
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign is_prime = r_is_prime;
    assign factor   = r_factor;

endmodule

// File: tb/tb_prime_seq_ctrl.sv
// Testbench for prime_seq_ctrl: directed and random operands checked against
// an arithmetic model of trial division (verdict, factor, CHECK-cycle count).
module tb_prime_seq_ctrl;

    localparam int N   = 10;
    localparam int TMO = 1100;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a;
    logic         busy;
    logic         done;
    logic         is_prime;
    logic [N-1:0] factor;

    int checks   = 0;
    int failures = 0;

    // Result the model says the outputs should currently be holding.
    bit m_p = 1'b0;
    int m_f = 0;

    prime_seq_ctrl #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .busy     (busy),
        .done     (done),
        .is_prime (is_prime),
        .factor   (factor)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: smallest divisor by plain search; latency from the rules.
    function automatic void model(input int v, output bit p, output int f, output int cyc);
        int d;
        if (v < 2) begin
            p = 1'b0; f = 0; cyc = 1;
            return;
        end
        d = 2;
        while (v % d != 0) d++;
        if (d == v) begin
            p = 1'b1; f = 0;
`ifdef PRIME_SQRT_BOUND_EN
            cyc = 0;
            while ((cyc + 1) * (cyc + 1) <= v) cyc++;
`else
            cyc = v - 1;
`endif
        end else begin
            p = 1'b0; f = d; cyc = d - 1;
        end
    endfunction

    // Called at a negedge; pulses start for one cycle and observes the test.
    // Returns at the negedge of the cycle after done (IDLE).
    task automatic run_one(input int v, output int lat, output bit p, output int f,
                           output bit pulse_ok, output bit held_ok, output bit tmo);
        start = 1'b1;
        a     = N'(v);
        @(negedge clk);
        start   = 1'b0;
        a       = N'($urandom);
        lat     = 0;
        held_ok = 1'b1;
        tmo     = 1'b0;
        while (done !== 1'b1 && !tmo) begin
            if (lat >= TMO) begin
                tmo = 1'b1;
            end else begin
                if (busy !== 1'b1 || is_prime !== m_p || factor !== N'(m_f)) held_ok = 1'b0;
                lat++;
                @(negedge clk);
                a = N'($urandom);
            end
        end
        p        = is_prime;
        f        = int'(factor);
        pulse_ok = (busy === 1'b1);
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0) pulse_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        a     = N'(5);
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0)     begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (is_prime !== 1'b0) begin failures++; $display("FAIL reset_is_prime got=%b want=0", is_prime); end
        checks++; if (factor !== '0)     begin failures++; $display("FAIL reset_factor got=%0d want=0", factor); end
        rst_n = 1'b1;
        start = 1'b0;
        m_p = 1'b0; m_f = 0;
        @(negedge clk);
    endtask

    // Runs a list of operands, each starting in the cycle after the previous
    // done, and compares every run with the model.
    task automatic test_sequence(input string tag, input int ops[$]);
        int lat, f, ef, ec;
        bit p, ep, pulse_ok, held_ok, tmo;
        foreach (ops[k]) begin
            run_one(ops[k], lat, p, f, pulse_ok, held_ok, tmo);
            model(ops[k], ep, ef, ec);
            checks++;
            if (tmo) begin
                failures++;
                $display("FAIL %s_timeout a=%0d no done within %0d cycles", tag, ops[k], TMO);
            end else begin
                checks++; if (lat != ec)  begin failures++; $display("FAIL %s_latency a=%0d got=%0d want=%0d", tag, ops[k], lat, ec); end
                checks++; if (p !== ep)   begin failures++; $display("FAIL %s_is_prime a=%0d got=%b want=%b", tag, ops[k], p, ep); end
                checks++; if (f != ef)    begin failures++; $display("FAIL %s_factor a=%0d got=%0d want=%0d", tag, ops[k], f, ef); end
                checks++; if (!pulse_ok)  begin failures++; $display("FAIL %s_done_pulse a=%0d got=not_single want=single_with_busy", tag, ops[k]); end
                checks++; if (!held_ok)   begin failures++; $display("FAIL %s_held a=%0d got=changed want=prev_%0b_%0d", tag, ops[k], m_p, m_f); end
            end
            m_p = ep; m_f = ef;
        end
    endtask

    task automatic test_composite_prime();
        test_sequence("main", '{221, 523});
    endtask

    task automatic test_edges();
        test_sequence("edge", '{0, 1, 2, 4, 3, 1023});
    endtask

    task automatic test_ignore_start();
        start = 1'b1;
        a     = N'(220);
        @(negedge clk);                     // first CHECK cycle
        a = N'(526);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL ign_check busy/done got=%b/%b want=1/0", busy, done); end
        @(negedge clk);                     // DONE cycle, start still high
        checks++; if (done !== 1'b1)     begin failures++; $display("FAIL ign_done got=%b want=1", done); end
        checks++; if (is_prime !== 1'b0) begin failures++; $display("FAIL ign_is_prime got=%b want=0", is_prime); end
        checks++; if (factor !== N'(2))  begin failures++; $display("FAIL ign_factor got=%0d want=2", factor); end
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL ign_idle busy/done got=%b/%b want=0/0", busy, done); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || factor !== N'(2)) begin failures++; $display("FAIL ign_stay busy/factor got=%b/%0d want=0/2", busy, factor); end
        m_p = 1'b0; m_f = 2;
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        start = 1'b1;
        a     = N'(523);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL rmid_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0)     begin failures++; $display("FAIL rmid_done got=%b want=0", done); end
        checks++; if (is_prime !== 1'b0) begin failures++; $display("FAIL rmid_is_prime got=%b want=0", is_prime); end
        checks++; if (factor !== '0)     begin failures++; $display("FAIL rmid_factor got=%0d want=0", factor); end
        m_p = 1'b0; m_f = 0;
        repeat (600) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin failures++; $display("FAIL rmid_no_done got=activity want=idle"); end
        test_sequence("rmid", '{564});
    endtask

    task automatic test_back_to_back();
        test_sequence("b2b", '{221, 1021, 220, 961});
    endtask

    task automatic test_random();
        int ops[$];
        for (int k = 0; k < 12; k++) ops.push_back(int'($urandom_range(0, (1 << N) - 1)));
        test_sequence("rand", ops);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        @(negedge clk);
        test_reset();
        test_composite_prime();
        test_edges();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
